sad_search_ctrl: RTL and testbench

- Sequences the SAD datapath (Memory -> SAD1 -> SAD2 stages) across every candidate window position of a search frame.
- Issues one window-fetch request per position in raster order and throttles the number of requests in flight.
- Consumes the in-order SAD results and tracks the running minimum SAD and its (x,y) coordinates.
- Sits between instruction decode (start/config) and the SAD pipeline; V0/V1-style results are read from its outputs.

---
 rtl/sad_search_ctrl_pkg.sv | 26 ++
 rtl/sad_search_ctrl_if.sv | 25 ++
 rtl/sad_search_ctrl_raster_counter.sv | 56 +++++
 rtl/sad_search_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_search_ctrl_pkg.sv
// Shared state encoding, widths and window address helper for the SAD search controller.
package sad_search_ctrl_pkg;

  localparam int COORD_W   = 16;
  localparam int SAD_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Byte address of a window's top-left word; wraps modulo 2^32.
  function automatic logic [31:0] win_addr(
    input logic [31:0]        base,
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [31:0]        frame_w
  );
    logic [31:0] word_idx;
    word_idx = (32'(y) * frame_w) + 32'(x);
    return base + (word_idx << 2);
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Window-fetch request and in-order SAD result channel between controller and pipeline.
interface sad_search_ctrl_if #(
  parameter int SAD_W = sad_search_ctrl_pkg::SAD_W_DEF
);
  import sad_search_ctrl_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               sad_valid;
  logic [SAD_W-1:0]   sad_value;

  modport master (
    output req_valid, req_addr, req_x, req_y,
    input  req_ready, sad_valid, sad_value
  );

  modport slave (
    input  req_valid, req_addr, req_x, req_y,
    output req_ready, sad_valid, sad_value
  );

endinterface

// File: rtl/sad_search_ctrl_raster_counter.sv
// Raster-order position counter: x runs 0..X_LAST, then wraps to 0 and y advances.
module sad_search_ctrl_raster_counter
  import sad_search_ctrl_pkg::*;
#(
  parameter int X_LAST = 60,
  parameter int Y_LAST = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               x_wrap_s;

  assign x_wrap_s = (x_q == COORD_W'(X_LAST));
  assign last_o   = x_wrap_s && (y_q == COORD_W'(Y_LAST));
  assign x_o      = x_q;
  assign y_o      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_wrap_s) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Walks every window position of a frame, throttles fetch requests in flight and
// tracks the minimum SAD result with its coordinates.
module sad_search_ctrl
  import sad_search_ctrl_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN_W   = 4,
  parameter int WIN_H   = 4,
  parameter int SAD_W   = SAD_W_DEF,
  parameter int MAX_OUT = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [31:0]        frame_base_i,
  sad_search_ctrl_if.master  bus,
  output logic               busy_o,
  output logic               done_o,
  output logic [SAD_W-1:0]   min_sad_o,
  output logic [COORD_W-1:0] min_x_o,
  output logic [COORD_W-1:0] min_y_o,
  output logic               err_o
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_e             state_q, state_d;
  logic [31:0]        base_q;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [SAD_W-1:0]   min_sad_q;
  logic [COORD_W-1:0] min_x_q, min_y_q;
  logic               err_q;

  logic [COORD_W-1:0] iss_x_s, iss_y_s, ret_x_s, ret_y_s;
  logic               iss_last_s, ret_last_s;
  logic               start_acc_s, active_s, issue_hs_s, ret_ok_s;

  assign start_acc_s = (state_q == ST_IDLE) && start_i;
  assign active_s    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign issue_hs_s  = bus.req_valid && bus.req_ready;
  // A result is only legal while searching and with something outstanding.
  assign ret_ok_s    = bus.sad_valid && active_s && (out_cnt_q != '0);

  sad_search_ctrl_raster_counter #(
    .X_LAST (FRAME_W - WIN_W),
    .Y_LAST (FRAME_H - WIN_H)
  ) u_issue_pos (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .clr_i  (start_acc_s),
    .adv_i  (issue_hs_s),
    .x_o    (iss_x_s),
    .y_o    (iss_y_s),
    .last_o (iss_last_s)
  );

  sad_search_ctrl_raster_counter #(
    .X_LAST (FRAME_W - WIN_W),
    .Y_LAST (FRAME_H - WIN_H)
  ) u_return_pos (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .clr_i  (start_acc_s),
    .adv_i  (ret_ok_s),
    .x_o    (ret_x_s),
    .y_o    (ret_y_s),
    .last_o (ret_last_s)
  );

  assign bus.req_addr = win_addr(base_q, iss_x_s, iss_y_s, 32'(FRAME_W));
  assign bus.req_x    = iss_x_s;
  assign bus.req_y    = iss_y_s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ISSUE;
        else         state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (issue_hs_s && iss_last_s) state_d = ST_DRAIN;
        else                          state_d = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (ret_ok_s && ret_last_s) state_d = ST_DONE;
        else                        state_d = ST_DRAIN;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request valid looks only at the registered count, so a same-cycle return frees no slot.
  always_comb begin
    bus.req_valid = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_valid = 1'b0;
      end
      ST_ISSUE: begin
        bus.req_valid = (out_cnt_q < OUT_W'(MAX_OUT));
        busy_o        = 1'b1;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        bus.req_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (start_acc_s) begin
      out_cnt_d = '0;
    end else if (issue_hs_s && !ret_ok_s) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (!issue_hs_s && ret_ok_s) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // Strict less-than keeps the earliest position on ties.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      base_q    <= 32'h0000_0000;
      out_cnt_q <= '0;
      min_sad_q <= '1;
      min_x_q   <= '0;
      min_y_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      if (start_acc_s) begin
        base_q    <= frame_base_i;
        min_sad_q <= '1;
        min_x_q   <= '0;
        min_y_q   <= '0;
      end else if (ret_ok_s && (bus.sad_value < min_sad_q)) begin
        min_sad_q <= bus.sad_value;
        min_x_q   <= ret_x_s;
        min_y_q   <= ret_y_s;
      end
      if (bus.sad_valid && !ret_ok_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign min_sad_o = min_sad_q;
  assign min_x_o   = min_x_q;
  assign min_y_o   = min_y_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scenario bench for sad_search_ctrl on an 8x8 frame with 4x4 windows; a scoreboard
// checks every accepted request and a delay queue models the SAD pipeline.
module tb_sad_search_ctrl;

  localparam int FW   = 8;
  localparam int FH   = 8;
  localparam int WW   = 4;
  localparam int WH   = 4;
  localparam int NX   = FW - WW + 1;
  localparam int NY   = FH - WH + 1;
  localparam int NPOS = NX * NY;
  localparam int MAXO = 4;
  localparam int LAT  = 3;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] x;
    logic [15:0] y;
  } req_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] frame_base;
  logic        busy, done, err;
  logic [31:0] min_sad;
  logic [15:0] min_x, min_y;

  sad_search_ctrl_if #(.SAD_W(32)) bus();

  sad_search_ctrl #(
    .FRAME_W(FW), .FRAME_H(FH), .WIN_W(WW), .WIN_H(WH), .SAD_W(32), .MAX_OUT(MAXO)
  ) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .frame_base_i(frame_base),
    .bus(bus.master), .busy_o(busy), .done_o(done), .min_sad_o(min_sad),
    .min_x_o(min_x), .min_y_o(min_y), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_count = 0;
  int          done_count = 0;
  int          out_model = 0;
  int          out_max = 0;
  int          cyc = 0;
  int          stop_hs = 0;
  bit          hold_ret = 1'b0;
  bit          stop_two = 1'b0;
  bit          rand_ready = 1'b0;
  int          sad_map [NX][NY];
  logic [31:0] obs_addr [NX][NY];
  req_t        exp_q [$];
  int          due_q [$];
  logic [31:0] val_q [$];
  logic [31:0] exp_min;
  logic [15:0] exp_x, exp_y;

  task automatic set_map(input int v);
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        sad_map[x][y] = v;
  endtask

  // Expected request stream and expected minimum, both in raster order.
  task automatic prep_search(input logic [31:0] base);
    req_t r;
    exp_q.delete();
    exp_min = 32'hFFFF_FFFF;
    exp_x   = 16'd0;
    exp_y   = 16'd0;
    for (int y = 0; y < NY; y++) begin
      for (int x = 0; x < NX; x++) begin
        r.x    = 16'(x);
        r.y    = 16'(y);
        r.addr = base + 32'((y * FW + x) * 4);
        exp_q.push_back(r);
        if (32'(sad_map[x][y]) < exp_min) begin
          exp_min = 32'(sad_map[x][y]);
          exp_x   = 16'(x);
          exp_y   = 16'(y);
        end
      end
    end
  endtask

  // One clock: monitor at negedge, then pipeline responder just after posedge.
  task automatic tick();
    int   out_pre;
    bit   hs, ret, fire;
    req_t e;
    @(negedge clk);
    if (rst) begin
      out_model = 0;
    end else begin
      out_pre = out_model;
      hs  = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
      ret = (bus.sad_valid === 1'b1) && (out_pre > 0);
      if (hs) begin
        hs_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_req unexpected request x=%0d y=%0d addr=%h", bus.req_x, bus.req_y, bus.req_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.req_addr !== e.addr || bus.req_x !== e.x || bus.req_y !== e.y)
            $display("FAIL sb_req got x=%0d y=%0d addr=%h want x=%0d y=%0d addr=%h",
                     bus.req_x, bus.req_y, bus.req_addr, e.x, e.y, e.addr);
          else
            n_pass++;
          obs_addr[e.x][e.y] = bus.req_addr;
          due_q.push_back(cyc + LAT);
          val_q.push_back(32'(sad_map[e.x][e.y]));
        end
      end
      out_model = out_pre + (hs ? 1 : 0) - (ret ? 1 : 0);
      if (out_model > out_max) out_max = out_model;
      if (done === 1'b1) done_count++;
    end
    @(posedge clk);
    #1;
    cyc++;
    fire = !hold_ret && (due_q.size() > 0) &&
           !(stop_two && hs_count == stop_hs && out_model <= 2);
    if (fire) fire = (due_q[0] <= cyc);
    if (fire) begin
      void'(due_q.pop_front());
      bus.sad_valid = 1'b1;
      bus.sad_value = val_q.pop_front();
    end else begin
      bus.sad_valid = 1'b0;
    end
    if (rand_ready) bus.req_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bus.req_ready = 1'b0; bus.sad_valid = 1'b0;
    hold_ret = 1'b0; stop_two = 1'b0; rand_ready = 1'b0;
    due_q.delete(); val_q.delete(); exp_q.delete();
    tick(); tick();
    bus.sad_valid = 1'b0;
    rst = 1'b0;
    out_max = 0;
  endtask

  task automatic start_search(input logic [31:0] base);
    prep_search(base);
    frame_base = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", bus.req_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
    n_checks++; if (min_sad !== 32'hFFFF_FFFF) $display("FAIL rst_min_sad got %h want ffffffff", min_sad); else n_pass++;
    n_checks++; if (min_x !== 16'd0 || min_y !== 16'd0) $display("FAIL rst_min_xy got %0d,%0d want 0,0", min_x, min_y); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    int h0, d0;
    do_reset();
    set_map(100);
    sad_map[3][2] = 7;
    h0 = hs_count; d0 = done_count;
    bus.req_ready = 1'b1;
    start_search(32'h0000_0100);
    n_checks++; if (busy !== 1'b1 || bus.req_valid !== 1'b1) $display("FAIL basic_first_req got busy=%b valid=%b want 1,1", busy, bus.req_valid); else n_pass++;
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL basic_timeout got no done want done"); else n_pass++;
    n_checks++; if (min_sad !== exp_min || min_sad !== 32'd7) $display("FAIL basic_min_sad got %0d want 7", min_sad); else n_pass++;
    n_checks++; if (min_x !== exp_x || min_y !== exp_y) $display("FAIL basic_min_xy got %0d,%0d want %0d,%0d", min_x, min_y, exp_x, exp_y); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else n_pass++;
    n_checks++; if (done_count - d0 !== 1) $display("FAIL basic_done_count got %0d want 1", done_count - d0); else n_pass++;
    n_checks++; if (hs_count - h0 !== NPOS) $display("FAIL basic_req_count got %0d want %0d", hs_count - h0, NPOS); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_addresses();
    n_checks++; if (obs_addr[1][0] !== 32'h0000_0104) $display("FAIL addr_1_0 got %h want 00000104", obs_addr[1][0]); else n_pass++;
    n_checks++; if (obs_addr[0][1] !== 32'h0000_0120) $display("FAIL addr_0_1 got %h want 00000120", obs_addr[0][1]); else n_pass++;
    n_checks++; if (obs_addr[4][4] !== 32'h0000_0190) $display("FAIL addr_4_4 got %h want 00000190", obs_addr[4][4]); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    int h0;
    do_reset();
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        sad_map[x][y] = 200 - ((x * 7 + y * 13) % 40);
    h0 = hs_count;
    start_search(32'h0000_2000);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.req_valid !== 1'b1) $display("FAIL stall_valid got %b want 1", bus.req_valid); else n_pass++;
      n_checks++; if (bus.req_addr !== 32'h0000_2000 || bus.req_x !== 16'd0) $display("FAIL stall_addr got %h want 00002000", bus.req_addr); else n_pass++;
      tick();
    end
    hold_ret = 1'b1;
    bus.req_ready = 1'b1;
    for (int i = 0; i < 20 && (hs_count - h0) < MAXO; i++) tick();
    n_checks++; if (bus.req_valid !== 1'b0) $display("FAIL stall_full got valid=%b want 0", bus.req_valid); else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.req_valid !== 1'b0 || hs_count - h0 !== MAXO) $display("FAIL stall_hold got valid=%b reqs=%0d want 0,%0d", bus.req_valid, hs_count - h0, MAXO); else n_pass++;
    hold_ret = 1'b0;
    tick();
    n_checks++; if (bus.req_valid !== 1'b0) $display("FAIL stall_same_cycle got valid=%b want 0", bus.req_valid); else n_pass++;
    hold_ret = 1'b1;
    tick();
    n_checks++; if (bus.req_valid !== 1'b1) $display("FAIL stall_reassert got valid=%b want 1", bus.req_valid); else n_pass++;
    hold_ret = 1'b0;
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL stall_timeout got no done want done"); else n_pass++;
    n_checks++; if (min_sad !== exp_min || min_x !== exp_x || min_y !== exp_y) $display("FAIL stall_min got %0d@%0d,%0d want %0d@%0d,%0d", min_sad, min_x, min_y, exp_min, exp_x, exp_y); else n_pass++;
    n_checks++; if (out_max !== MAXO) $display("FAIL stall_max_out got %0d want %0d", out_max, MAXO); else n_pass++;
  endtask

  task automatic test_tie();
    bit ok;
    do_reset();
    set_map(100);
    sad_map[1][0] = 5;
    sad_map[2][3] = 5;
    rand_ready = 1'b1;
    bus.req_ready = 1'b1;
    start_search(32'hFFFF_FFF0);
    wait_done(2000, ok);
    rand_ready = 1'b0;
    n_checks++; if (!ok) $display("FAIL tie_timeout got no done want done"); else n_pass++;
    n_checks++; if (min_sad !== 32'd5) $display("FAIL tie_min_sad got %0d want 5", min_sad); else n_pass++;
    n_checks++; if (min_x !== 16'd1 || min_y !== 16'd0) $display("FAIL tie_min_xy got %0d,%0d want 1,0", min_x, min_y); else n_pass++;
    n_checks++; if (out_max > MAXO) $display("FAIL tie_max_out got %0d want <=%0d", out_max, MAXO); else n_pass++;
  endtask

  task automatic test_reset_drain();
    int h0, d0;
    do_reset();
    set_map(100);
    bus.req_ready = 1'b1;
    h0 = hs_count; d0 = done_count;
    stop_hs = h0 + NPOS;
    stop_two = 1'b1;
    start_search(32'h0000_0100);
    for (int i = 0; i < 200 && !(hs_count == stop_hs && out_model == 2); i++) tick();
    n_checks++; if (busy !== 1'b1 || bus.req_valid !== 1'b0 || out_model !== 2) $display("FAIL drain_state got busy=%b valid=%b out=%0d want 1,0,2", busy, bus.req_valid, out_model); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stop_two = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.req_valid !== 1'b0 || done !== 1'b0) $display("FAIL drain_rst_ctrl got busy=%b valid=%b done=%b want 0,0,0", busy, bus.req_valid, done); else n_pass++;
    n_checks++; if (min_sad !== 32'hFFFF_FFFF || min_x !== 16'd0 || min_y !== 16'd0) $display("FAIL drain_rst_min got %h@%0d,%0d want ffffffff@0,0", min_sad, min_x, min_y); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL drain_rst_err got %b want 0", err); else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (err !== 1'b1) $display("FAIL drain_late_err got %b want 1", err); else n_pass++;
    n_checks++; if (min_sad !== 32'hFFFF_FFFF || busy !== 1'b0) $display("FAIL drain_late_ignored got min=%h busy=%b want ffffffff,0", min_sad, busy); else n_pass++;
    n_checks++; if (done_count !== d0) $display("FAIL drain_no_done got %0d want %0d", done_count - d0, 0); else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int h0, d0;
    do_reset();
    set_map(100);
    sad_map[4][4] = 1;
    bus.req_ready = 1'b1;
    h0 = hs_count; d0 = done_count;
    start_search(32'h0000_0400);
    for (int i = 0; i < 6; i++) tick();
    frame_base = 32'hFFFF_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL restart_timeout got no done want done"); else n_pass++;
    n_checks++; if (min_sad !== 32'd1 || min_x !== 16'd4 || min_y !== 16'd4) $display("FAIL restart_min got %0d@%0d,%0d want 1@4,4", min_sad, min_x, min_y); else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (done_count - d0 !== 1) $display("FAIL restart_done_count got %0d want 1", done_count - d0); else n_pass++;
    n_checks++; if (hs_count - h0 !== NPOS || exp_q.size() !== 0) $display("FAIL restart_reqs got %0d left=%0d want %0d,0", hs_count - h0, exp_q.size(), NPOS); else n_pass++;
    n_checks++; if (busy !== 1'b0 || bus.req_valid !== 1'b0 || err !== 1'b0) $display("FAIL restart_idle got busy=%b valid=%b err=%b want 0,0,0", busy, bus.req_valid, err); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_base = 32'h0000_0000;
    bus.req_ready = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_value = 32'h0000_0000;
    set_map(100);
    test_reset();
    test_basic();
    test_addresses();
    test_stall();
    test_tie();
    test_reset_drain();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
